// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks: Gray/binary conversion
// and the depth rule. Functions run at full 32-bit width; callers zero-extend and slice.
package fifo_pkg;

  localparam int unsigned CONV_W = 32;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it. Zero
  // padding above the real width leaves the result unchanged.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b = '0;
    for (int i = 0; i < CONV_W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_af.sv
// Write-domain pointer/flag block of the async FIFO: binary address, Gray
// pointer for the synchroniser, full/almost-full, fill estimate, sticky overflow.
module wptr_full_af
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  wovf_clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0]     r_wbin;
  logic [PW-1:0]     r_wptr;
  logic              r_wfull;
  logic              r_walmost_full;
  logic [PW-1:0]     r_wlevel;
  logic              r_woverflow;

  logic              w_wen;
  logic [PW-1:0]     w_wbinnext;
  logic [CONV_W-1:0] w_gray_full;
  logic [PW-1:0]     w_wgraynext;
  logic [CONV_W-1:0] w_rbin_full;
  logic [PW-1:0]     w_rbin_s;
  logic [PW-1:0]     w_wlevel_next;
  logic [PW-1:0]     w_full_cmp;
  logic              w_wfull_val;
  logic              w_afull_val;

  assign w_wen       = winc & ~r_wfull;
  assign w_wbinnext  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_wen};
  assign w_gray_full = bin2gray(CONV_W'(w_wbinnext));
  assign w_wgraynext = w_gray_full[PW-1:0];

  // Full when the next write pointer is one lap ahead of the synced read
  // pointer: in Gray code that is the top two bits inverted.
  assign w_full_cmp  = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
  assign w_wfull_val = (w_wgraynext == w_full_cmp);

  assign w_rbin_full   = gray2bin(CONV_W'(wq2_rptr));
  assign w_rbin_s      = w_rbin_full[PW-1:0];
  assign w_wlevel_next = w_wbinnext - w_rbin_s;
  assign w_afull_val   = (CONV_W'(w_wlevel_next) >= AFULL_THRESH);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_wbinnext;
      r_wptr         <= w_wgraynext;
      r_wfull        <= w_wfull_val;
      r_walmost_full <= w_afull_val;
      r_wlevel       <= w_wlevel_next;
      // A dropped write in the same cycle as a clear must not be lost.
      if (winc & r_wfull)  r_woverflow <= 1'b1;
      else if (wovf_clr)   r_woverflow <= 1'b0;
    end
  end

  assign waddr        = r_wbin[ADDR_WIDTH-1:0];
  assign wptr         = r_wptr;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
  assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_wptr_full_af.sv
// Directed bench for wptr_full_af: fill, overflow, drain via synced read
// pointer, wrap with one-bit Gray steps, async reset mid-burst.
module tb_wptr_full_af;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic [3:0] wq2_rptr = '0;
  logic       wovf_clr = 1'b0;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  int errors = 0;
  int checks = 0;

  wptr_full_af #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .wovf_clr(wovf_clr), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge before sampling.
  task automatic step();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".waddr"}, 32'(waddr), 0);
    chk({tag, ".wptr"},  32'(wptr), 0);
    chk({tag, ".wfull"}, 32'(wfull), 0);
    chk({tag, ".afull"}, 32'(walmost_full), 0);
    chk({tag, ".wlevel"}, 32'(wlevel), 0);
    chk({tag, ".ovf"},   32'(woverflow), 0);
  endtask

  initial begin
    logic [3:0] exp_bin;
    logic [3:0] prev_ptr;

    #12;
    chk_all_zero("rst_hold");
    @(negedge wclk);
    wrst_n = 1'b1;
    step();
    chk_all_zero("idle");

    // Fill eight entries against an idle reader.
    winc = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("fill_addr%0d", k), 32'(waddr), 32'(k - 1));
      step();
      chk($sformatf("fill_lvl%0d", k),  32'(wlevel), 32'(k));
      chk($sformatf("fill_af%0d", k),   32'(walmost_full), (k >= 6) ? 1 : 0);
      chk($sformatf("fill_full%0d", k), 32'(wfull), (k == 8) ? 1 : 0);
    end
    chk("full_wptr", 32'(wptr), 32'h0000000c);

    // Writes while full are dropped and flagged.
    for (int k = 0; k < 3; k++) step();
    chk("ovf_wptr",  32'(wptr), 32'hc);
    chk("ovf_addr",  32'(waddr), 0);
    chk("ovf_set",   32'(woverflow), 1);
    chk("ovf_full",  32'(wfull), 1);
    wovf_clr = 1'b1;
    step();
    chk("ovf_setwins", 32'(woverflow), 1);
    winc = 1'b0;
    step();
    chk("ovf_clr", 32'(woverflow), 0);
    wovf_clr = 1'b0;

    // Reader advances to 2, then 3.
    wq2_rptr = 4'b0011;
    step();
    chk("rd2_full", 32'(wfull), 0);
    chk("rd2_lvl",  32'(wlevel), 6);
    chk("rd2_af",   32'(walmost_full), 1);
    wq2_rptr = 4'b0010;
    step();
    chk("rd3_lvl", 32'(wlevel), 5);
    chk("rd3_af",  32'(walmost_full), 0);

    // Wrap: sixteen writes with the reader two behind.
    exp_bin = 4'd8;
    winc = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wq2_rptr = g4(exp_bin - 4'd2);
      prev_ptr = wptr;
      step();
      exp_bin = exp_bin + 4'd1;
      chk($sformatf("wrap_ptr%0d", k),  32'(wptr), 32'(g4(exp_bin)));
      chk($sformatf("wrap_1bit%0d", k), 32'($countones(wptr ^ prev_ptr)), 1);
      chk($sformatf("wrap_addr%0d", k), 32'(waddr), 32'(exp_bin[2:0]));
      chk($sformatf("wrap_full%0d", k), 32'(wfull), 0);
      chk($sformatf("wrap_lvl%0d", k),  32'(wlevel), 3);
      if (exp_bin == 4'd0) chk("wrap_zero", 32'(wptr), 0);
    end

    // Async reset between edges, mid-burst.
    step();
    step();
    #2;
    wrst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    wq2_rptr = '0;
    @(negedge wclk);
    wrst_n = 1'b1;
    chk("post_rst_addr0", 32'(waddr), 0);
    step();
    chk("post_rst_addr1", 32'(waddr), 1);
    chk("post_rst_lvl",   32'(wlevel), 1);
    chk("post_rst_ptr",   32'(wptr), 1);
    winc = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wptr_full_af.md
Name: wptr_full_af

Overview:
- Write-side pointer and flag logic for the asynchronous FIFO. Lives entirely in the write clock domain.
- Maintains the binary write address and the registered Gray write pointer, which goes to the write-to-read synchroniser.
- Compares against the read pointer already synchronised into the write domain. From that it produces registered full and almost-full flags, a fill-level estimate and a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 3, address bits; FIFO depth = 2^ADDR_WIDTH.
- AFULL_THRESH, 6, fill level at or above which walmost_full asserts; legal range 1..2^ADDR_WIDTH.

Ports:
- wclk  input  1  write clock.
- wrst_n  input  1  asynchronous active-low reset.
- winc  input  1  write request.
- wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, synchronised to wclk.
- wovf_clr  input  1  clears woverflow.
- waddr  output  ADDR_WIDTH  RAM write address.
- wptr  output  ADDR_WIDTH+1  registered Gray write pointer, to the synchroniser.
- wfull  output  1  registered full flag.
- walmost_full  output  1  registered almost-full flag.
- wlevel  output  ADDR_WIDTH+1  registered fill estimate, 0..2^ADDR_WIDTH.
- woverflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Clock and reset: one clock, wclk; reset wrst_n is asynchronous and active-low.
- Reset values (async, immediate, including mid-operation): wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
- Accepted write: wen = winc & ~wfull.
- Next pointers:
  - wbinnext = wbin + wen, modulo 2^(ADDR_WIDTH+1).
  - wgraynext = (wbinnext>>1) ^ wbinnext.
- Register update each wclk: wbin<=wbinnext; wptr<=wgraynext.
- waddr = wbin[ADDR_WIDTH-1:0] (combinational from register). The RAM write strobe is wen, external to this block.
- Full detection:
  - wfull_val = (wgraynext == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
  - wfull<=wfull_val.
  - Consequence: wfull asserts the cycle after the write that fills the FIFO, with no extra latency.
  - Consequence: wfull deasserts one cycle after the full condition stops matching wq2_rptr.
- Level:
  - rbin_s = gray-to-binary of wq2_rptr.
  - wlevel_next = wbinnext - rbin_s, modulo 2^(ADDR_WIDTH+1).
  - wlevel<=wlevel_next.
  - walmost_full<=(wlevel_next >= AFULL_THRESH).
  - wlevel is pessimistic (never under-reports), because wq2_rptr lags the real read pointer.
- Overflow:
  - If winc & wfull, woverflow<=1.
  - Else if wovf_clr, woverflow<=0.
  - Set wins over a simultaneous clear.
- Write while full: ignored. No pointer change, waddr holds, data is dropped by the RAM strobe gating.
- Wrap-around: wbin rolls from 2^(ADDR_WIDTH+1)-1 to 0 silently. The MSB toggling distinguishes full from empty.
- Flag invariants:
  - wfull implies wlevel == 2^ADDR_WIDTH.
  - wfull implies walmost_full.
- Pointer rule: only one bit of wptr may change per cycle; this is required for safe synchronisation.

Decomposition:
- Shared package fifo_pkg, containing:
  - functions bin2gray and gray2bin, parameterised by width;
  - a localparam rule for DEPTH = 1<<ADDR_WIDTH.
- The read-side block imports the same package.
- No sub-module is needed. The gray-to-binary conversion is a function, not an instance.

Test Plan:
- Reset, then hold winc=0 with wq2_rptr=0 -> waddr=0, wptr=4'b0000, all flags 0, wlevel=0.
- Eight consecutive writes, wq2_rptr=0 ->
  - waddr steps 0..7;
  - walmost_full=1 the cycle after the 6th write;
  - wfull=1 and wlevel=8 the cycle after the 8th write;
  - wptr=4'b1100.
- While full, winc=1 for 3 cycles -> wptr stays at 4'b1100 and woverflow=1. Then wovf_clr=1 with winc=1 -> woverflow stays 1. Then wovf_clr=1 with winc=0 -> woverflow=0.
- From full, drive wq2_rptr=4'b0011 (binary 2) -> next cycle wfull=0, wlevel=6, walmost_full=1. Then wq2_rptr=4'b0010 (binary 3) -> wlevel=5, walmost_full=0.
- Wrap: 16 writes interleaved with a wq2_rptr that tracks two writes behind -> wbin wraps 15->0, wptr returns to 4'b0000, wfull never asserts, and every wptr transition changes exactly one bit.
- Assert wrst_n low mid-burst, between clock edges -> all outputs clear immediately. After release, the first write goes to waddr=0.
